dmem_store_buffer: RTL

DMEM_STORE_BUFFER -- requirements
Module: dmem_store_buffer

---
 rtl/dmem_store_buffer_if.sv | 31 +++
 rtl/dmem_store_buffer.sv | 91 +++++++++
 2 files changed

// File: rtl/dmem_store_buffer_if.sv
// Store-buffer bus bundle: MEM-stage store port, load lookup port, RAM write port and status.
// The master side is the pipeline/RAM environment, the slave side is the buffer itself.
interface dmem_store_buffer_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32,
  parameter int unsigned CW = 3
);
  logic          st_valid;
  logic [AW-1:0] st_addr;
  logic [DW-1:0] st_data;
  logic          st_ready;
  logic [AW-1:0] ld_addr;
  logic          ld_hit;
  logic [DW-1:0] ld_data;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wd;
  logic          mem_ack;
  logic          empty;
  logic [CW-1:0] count;

  modport master (
    output st_valid, st_addr, st_data, ld_addr, mem_ack,
    input  st_ready, ld_hit, ld_data, mem_we, mem_addr, mem_wd, empty, count
  );

  modport slave (
    input  st_valid, st_addr, st_data, ld_addr, mem_ack,
    output st_ready, ld_hit, ld_data, mem_we, mem_addr, mem_wd, empty, count
  );
endinterface

// File: rtl/dmem_store_buffer.sv
// Data-memory store buffer: circular FIFO of pending stores drained to RAM one at a time,
// with youngest-match store-to-load forwarding over the buffered entries.
module dmem_store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  dmem_store_buffer_if.slave   bus
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  typedef enum logic {IDLE, WRITE} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];

  logic          accept_c;
  logic          pop_c;
  logic          ld_hit_c;
  logic [DW-1:0] ld_data_c;
  logic [PW-1:0] fwd_idx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage needs no reset: only slots below count_q are ever observed.
  always_ff @(posedge clk) begin
    if (accept_c) begin
      addr_q[wr_ptr_q] <= bus.st_addr;
      data_q[wr_ptr_q] <= bus.st_data;
    end
  end

  always_comb begin
    accept_c = bus.st_valid && (count_q < CW'(DEPTH));
    pop_c    = (state_q == WRITE) && bus.mem_ack;
    wr_ptr_d = accept_c ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop_c    ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(accept_c) - CW'(pop_c);
    state_d  = state_q;
    case (state_q)
      IDLE:    if ((count_q != '0) || accept_c) state_d = WRITE;
      WRITE:   if (pop_c && (count_d == '0))     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Scan oldest to youngest so the last match (youngest store) wins.
  always_comb begin
    ld_hit_c  = 1'b0;
    ld_data_c = '0;
    fwd_idx   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      fwd_idx = rd_ptr_q + PW'(i);
      if ((CW'(i) < count_q) && (addr_q[fwd_idx] == bus.ld_addr)) begin
        ld_hit_c  = 1'b1;
        ld_data_c = data_q[fwd_idx];
      end
    end
  end

  assign bus.st_ready = (count_q < CW'(DEPTH));
  assign bus.empty    = (count_q == '0);
  assign bus.count    = count_q;
  assign bus.mem_we   = (state_q == WRITE);
  assign bus.mem_addr = (state_q == WRITE) ? addr_q[rd_ptr_q] : '0;
  assign bus.mem_wd   = (state_q == WRITE) ? data_q[rd_ptr_q] : '0;
  assign bus.ld_hit   = ld_hit_c;
  assign bus.ld_data  = ld_data_c;

endmodule
